// File: rtl/tri_pipe_sequencer.sv
// Frame-level triangle sequencer: keeps STAGES overlapped pipeline stages in lock-step,
// issuing fetch addresses for the triangle entering stage 0 and counting retirements.
module tri_pipe_sequencer #(
    parameter int MADDR_WIDTH   = 32,
    parameter int COUNT_WIDTH   = 32,
    parameter int STAGES        = 3,
    parameter int VERTEX_STRIDE = 18,
    parameter int COLOR_STRIDE  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_start,
    input  logic                   abort,
    input  logic [COUNT_WIDTH-1:0] triangles_count,
    input  logic [MADDR_WIDTH-1:0] base_addr_vertex,
    input  logic [MADDR_WIDTH-1:0] base_addr_color,
    input  logic [STAGES-1:0]      stage_eoc,
    output logic [STAGES-1:0]      stage_start,
    output logic [STAGES-1:0]      stage_valid,
    output logic                   advance,
    output logic [MADDR_WIDTH-1:0] fetch_addr_vertex,
    output logic [MADDR_WIDTH-1:0] fetch_addr_color,
    output logic                   busy,
    output logic                   frame_done,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                 state, state_next;
    logic [COUNT_WIDTH-1:0] count_q, issued_q;
    logic [STAGES-1:0]      done_q, eoc_m, stage_ready, new_valid;
    logic                   more;

    // Stage handshake: stage_start[k] is a one-cycle pulse handing stage k a triangle;
    // stage_eoc[k] counts only while the stage is valid and not in its start cycle,
    // and is remembered in done_q until the whole pipe advances together.
    assign eoc_m       = stage_eoc & stage_valid & ~stage_start;
    assign stage_ready = done_q | eoc_m | ~stage_valid;
    assign more        = issued_q < count_q;

    always_comb begin
        new_valid    = '0;
        new_valid[0] = more;
        for (int k = 1; k < STAGES; k++) begin
            new_valid[k] = stage_valid[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (frame_start && triangles_count != '0) state_next = RUN;
                RUN:     if (advance && new_valid == '0) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        advance = (state == RUN) && (&stage_ready) && !abort;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_start       <= '0;
            stage_valid       <= '0;
            done_q            <= '0;
            count_q           <= '0;
            issued_q          <= '0;
            retired_count     <= '0;
            fetch_addr_vertex <= '0;
            fetch_addr_color  <= '0;
            busy              <= 1'b0;
            frame_done        <= 1'b0;
        end else begin
            stage_start <= '0;
            frame_done  <= 1'b0;
            if (abort) begin
                stage_valid <= '0;
                done_q      <= '0;
                busy        <= 1'b0;
            end else if (state == IDLE) begin
                if (frame_start && triangles_count != '0) begin
                    count_q           <= triangles_count;
                    fetch_addr_vertex <= base_addr_vertex;
                    fetch_addr_color  <= base_addr_color;
                    issued_q          <= COUNT_WIDTH'(1);
                    retired_count     <= '0;
                    stage_valid       <= STAGES'(1);
                    stage_start       <= STAGES'(1);
                    done_q            <= '0;
                    busy              <= 1'b1;
                end else if (frame_start) begin
                    frame_done <= 1'b1;
                end
            end else if (advance) begin
                stage_valid <= new_valid;
                stage_start <= new_valid;
                done_q      <= '0;
                if (stage_valid[STAGES-1]) retired_count <= retired_count + COUNT_WIDTH'(1);
                if (more) begin
                    issued_q          <= issued_q + COUNT_WIDTH'(1);
                    fetch_addr_vertex <= fetch_addr_vertex + MADDR_WIDTH'(VERTEX_STRIDE);
                    fetch_addr_color  <= fetch_addr_color + MADDR_WIDTH'(COLOR_STRIDE);
                end
                if (new_valid == '0) begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                end
            end else begin
                done_q <= done_q | eoc_m;
            end
        end
    end

endmodule

// File: tb/tb_tri_pipe_sequencer.sv
// Randomised bench for tri_pipe_sequencer: a responder plays the stage cores, a
// frame-level model predicts fetch addresses and retirements, a monitor scores them.
module tb_tri_pipe_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] triangles_count = '0;
    logic [31:0] base_addr_vertex = '0;
    logic [31:0] base_addr_color = '0;
    logic [2:0]  stage_eoc = '0;
    logic [2:0]  stage_start, stage_valid;
    logic        advance, busy, frame_done;
    logic [31:0] fetch_addr_vertex, fetch_addr_color, retired_count;

    tri_pipe_sequencer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .frame_start       (frame_start),
        .abort             (abort),
        .triangles_count   (triangles_count),
        .base_addr_vertex  (base_addr_vertex),
        .base_addr_color   (base_addr_color),
        .stage_eoc         (stage_eoc),
        .stage_start       (stage_start),
        .stage_valid       (stage_valid),
        .advance           (advance),
        .fetch_addr_vertex (fetch_addr_vertex),
        .fetch_addr_color  (fetch_addr_color),
        .busy              (busy),
        .frame_done        (frame_done),
        .retired_count     (retired_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] v;
        logic [31:0] c;
    } fetch_t;
    typedef struct {
        int          tri_n;
        logic [31:0] retired;
    } done_t;

    fetch_t      exp_q[$];
    done_t       exp_done_q[$];
    logic [31:0] model_retired = '0;

    int dly_min[3] = '{1, 1, 1};
    int dly_max[3] = '{1, 1, 1};
    bit junk_en = 1'b0;
    bit eoc_all = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // stage-core responder: eoc some cycles after each start, plus ignorable noise
    logic [2:0] owed = '0;
    int         wait_c[3] = '{0, 0, 0};

    always @(negedge clk) begin
        logic [2:0] e;
        e = '0;
        if (!busy) owed = '0;
        if (eoc_all) begin
            e = '1;
        end else begin
            if (stage_start != '0) check("no_early_advance", 64'(owed), 64'(0));
            for (int k = 0; k < 3; k++) begin
                if (stage_start[k]) begin
                    owed[k]   = 1'b1;
                    wait_c[k] = $urandom_range(dly_max[k], dly_min[k]);
                    if (junk_en && $urandom_range(1, 0) == 1) e[k] = 1'b1;
                end else if (owed[k]) begin
                    if (wait_c[k] <= 1) begin
                        e[k]    = 1'b1;
                        owed[k] = 1'b0;
                    end else begin
                        wait_c[k]--;
                    end
                end else if (junk_en && !stage_valid[k] && $urandom_range(3, 0) == 0) begin
                    e[k] = 1'b1;
                end
            end
        end
        stage_eoc = e;
    end

    // scoreboard monitor
    bit prev_busy = 1'b0;
    int start_cnt[3] = '{0, 0, 0};

    always @(negedge clk) begin
        fetch_t f;
        done_t  d;
        if (abort || (busy && !prev_busy)) start_cnt = '{0, 0, 0};
        for (int k = 0; k < 3; k++) if (stage_start[k]) start_cnt[k]++;
        if (stage_start[0]) begin
            if (exp_q.size() == 0) begin
                check("unexpected_fetch", 64'(1), 64'(0));
            end else begin
                f = exp_q.pop_front();
                check("fetch_vertex", 64'(fetch_addr_vertex), 64'(f.v));
                check("fetch_color", 64'(fetch_addr_color), 64'(f.c));
            end
        end
        if (frame_done) begin
            if (exp_done_q.size() == 0) begin
                check("unexpected_frame_done", 64'(1), 64'(0));
            end else begin
                d = exp_done_q.pop_front();
                check("retired_at_done", 64'(retired_count), 64'(d.retired));
                for (int k = 0; k < 3; k++) check("starts_per_stage", 64'(start_cnt[k]), 64'(d.tri_n));
            end
            start_cnt = '{0, 0, 0};
        end
        prev_busy = busy;
    end

    // driver tasks
    task automatic set_delays(input int lo, input int hi);
        for (int k = 0; k < 3; k++) begin
            dly_min[k] = lo;
            dly_max[k] = hi;
        end
    endtask

    task automatic start_frame(input int n, input logic [31:0] bv, input logic [31:0] bc);
        done_t       d;
        fetch_t      f;
        logic [31:0] prev_ret;
        prev_ret = model_retired;
        for (int i = 0; i < n; i++) begin
            f.v = bv + 32'(i * 18);
            f.c = bc + 32'(i * 2);
            exp_q.push_back(f);
        end
        if (n > 0) model_retired = 32'(n);
        d.tri_n   = n;
        d.retired = model_retired;
        exp_done_q.push_back(d);
        @(posedge clk); #1;
        triangles_count  = 32'(n);
        base_addr_vertex = bv;
        base_addr_color  = bc;
        frame_start      = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        check("launch_busy", 64'(busy), 64'(n > 0));
        check("launch_frame_done", 64'(frame_done), 64'(n == 0));
        check("launch_start", 64'(stage_start), (n > 0) ? 64'(1) : 64'(0));
        check("launch_valid", 64'(stage_valid), (n > 0) ? 64'(1) : 64'(0));
        check("launch_retired", 64'(retired_count), (n > 0) ? 64'(0) : 64'(prev_ret));
        if (n > 0) begin
            check("launch_vertex", 64'(fetch_addr_vertex), 64'(bv));
            check("launch_color", 64'(fetch_addr_color), 64'(bc));
        end
    endtask

    task automatic wait_frame(input bit interfere, input bit track);
        int t1 = -1;
        int t2 = -1;
        int c = 0;
        while (busy && c < 2000) begin
            @(posedge clk); #1;
            c++;
            if (stage_start[1] && t1 < 0) t1 = c;
            if (stage_start[2] && t2 < 0) t2 = c;
            if (interfere && busy) begin
                frame_start     = ($urandom_range(7, 0) == 0);
                triangles_count = $urandom;
            end else begin
                frame_start = 1'b0;
            end
        end
        frame_start = 1'b0;
        check("frame_timeout", 64'(busy), 64'(0));
        if (track) begin
            check("stage1_start_cycle", 64'(t1), 64'(2));
            check("stage2_start_cycle", 64'(t2), 64'(4));
        end
        repeat (2) @(posedge clk);
        #1;
        check("fetch_queue_drained", 64'(exp_q.size()), 64'(0));
        check("done_queue_drained", 64'(exp_done_q.size()), 64'(0));
    endtask

    task automatic abort_test();
        int c = 0;
        bit saw_done = 1'b0;
        start_frame(5, 32'h0000_1000, 32'h0000_2000);
        while (retired_count != 32'd2 && c < 1000) begin
            @(posedge clk); #1;
            c++;
        end
        check("abort_wait_retired2", 64'(retired_count), 64'(2));
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_valid", 64'(stage_valid), 64'(0));
        check("abort_start", 64'(stage_start), 64'(0));
        check("abort_retired_hold", 64'(retired_count), 64'(2));
        for (int i = 0; i < 5; i++) begin
            if (frame_done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_frame_done", 64'(saw_done), 64'(0));
        exp_q.delete();
        exp_done_q.delete();
        model_retired = 32'd2;
    endtask

    initial begin
        // reset with start and eoc held high
        reset_n     = 1'b0;
        frame_start = 1'b1;
        eoc_all     = 1'b1;
        triangles_count = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_start", 64'(stage_start), 64'(0));
        check("reset_valid", 64'(stage_valid), 64'(0));
        check("reset_done", 64'(frame_done), 64'(0));
        check("reset_retired", 64'(retired_count), 64'(0));
        check("reset_vertex", 64'(fetch_addr_vertex), 64'(0));
        check("reset_color", 64'(fetch_addr_color), 64'(0));
        reset_n     = 1'b1;
        frame_start = 1'b0;
        eoc_all     = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", 64'(busy), 64'(0));
        check("post_reset_no_start", 64'(stage_start), 64'(0));

        // single triangle, eoc one cycle after each start
        set_delays(1, 1);
        start_frame(1, 32'h0000_1000, 32'h0000_2000);
        wait_frame(1'b0, 1'b1);

        // four triangles with a slow stage 1
        dly_min[1] = 5;
        dly_max[1] = 5;
        start_frame(4, 32'h0000_1000, 32'h0000_2000);
        wait_frame(1'b0, 1'b0);

        // empty frame
        set_delays(1, 3);
        start_frame(0, 32'h0000_3000, 32'h0000_4000);
        wait_frame(1'b0, 1'b0);

        // abort mid-frame, then restart from the bases
        junk_en = 1'b1;
        abort_test();
        start_frame(5, 32'h0000_1000, 32'h0000_2000);
        wait_frame(1'b0, 1'b0);

        // interference during run
        start_frame(6, 32'h0000_5000, 32'h0000_6000);
        wait_frame(1'b1, 1'b0);

        // address wrap
        start_frame(2, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        wait_frame(1'b0, 1'b0);

        // random frames
        for (int r = 0; r < 10; r++) begin
            int lo;
            lo = $urandom_range(3, 1);
            set_delays(lo, lo + $urandom_range(3, 0));
            junk_en = $urandom_range(1, 0);
            start_frame($urandom_range(7, 0), $urandom, $urandom);
            wait_frame($urandom_range(1, 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
